// File: rtl/multi_pulse_gen_if.sv
// Control/status bundle for multi_pulse_gen: per-channel triggers in, per-channel pulses and missed flags out.
interface multi_pulse_gen_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 8
);
  logic [N_CH-1:0]  trigger;
  logic [1:0]       edge_mode;
  logic [CNT_W-1:0] pulse_len;
  logic             retrig;
  logic             clr_missed;
  logic [N_CH-1:0]  pulse_out;
  logic [N_CH-1:0]  missed;

  modport master (
    output trigger, edge_mode, pulse_len, retrig, clr_missed,
    input  pulse_out, missed
  );

  modport slave (
    input  trigger, edge_mode, pulse_len, retrig, clr_missed,
    output pulse_out, missed
  );
endinterface

// File: rtl/multi_pulse_gen.sv
// Multi-channel edge-to-pulse generator: selectable edge detect, programmable pulse length,
// optional retrigger and sticky missed-edge flags. All outputs registered.
module multi_pulse_gen #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  multi_pulse_gen_if.slave    bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [N_CH-1:0]  trg_s;
  logic [N_CH-1:0]  trg_d;
  logic [N_CH-1:0]  qual;
  logic [CNT_W-1:0] load_val;
  logic [N_CH-1:0]  pulse_q;
  logic [N_CH-1:0]  missed_q;
  state_t           state_q [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];

  // Optional input synchroniser ahead of the edge detector
  if (SYNC_STAGES == 0) begin : g_nosync
    assign trg_s = bus.trigger;
  end else begin : g_sync
    logic [N_CH-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
        sync_q[0] <= bus.trigger;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign trg_s = sync_q[SYNC_STAGES-1];
  end

  // Edge qualification against the shared edge_mode; mode 11 never qualifies
  always_comb begin
    qual = '0;
    case (bus.edge_mode)
      2'b00:   qual = trg_s & ~trg_d;
      2'b01:   qual = ~trg_s & trg_d;
      2'b10:   qual = trg_s ^ trg_d;
      default: qual = '0;
    endcase
  end

  // A zero pulse length behaves as a single-cycle pulse
  assign load_val = (bus.pulse_len == '0) ? '0 : bus.pulse_len - CNT_W'(1);

  // Per-channel pulse FSM; a later missed-set overrides the broadcast clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trg_d    <= '0;
      pulse_q  <= '0;
      missed_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      trg_d <= trg_s;
      if (bus.clr_missed) missed_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        case (state_q[i])
          IDLE: begin
            if (qual[i]) begin
              pulse_q[i] <= 1'b1;
              cnt_q[i]   <= load_val;
              if (load_val != '0) state_q[i] <= ACTIVE;
            end else begin
              pulse_q[i] <= 1'b0;
            end
          end
          ACTIVE: begin
            if (qual[i] && bus.retrig) begin
              cnt_q[i] <= load_val;
            end else begin
              if (qual[i]) missed_q[i] <= 1'b1;
              if (cnt_q[i] == '0) begin
                pulse_q[i] <= 1'b0;
                state_q[i] <= IDLE;
              end else begin
                cnt_q[i] <= cnt_q[i] - CNT_W'(1);
              end
            end
          end
          default: begin
            pulse_q[i] <= 1'b0;
            state_q[i] <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.pulse_out = pulse_q;
  assign bus.missed    = missed_q;

endmodule

// File: doc/multi_pulse_gen.md
# multi_pulse_gen

Parametrised, multi-channel edge-to-pulse generator. Each channel detects a selectable edge on its trigger input and emits a registered output pulse of programmable length. Optional retriggering and a sticky missed-edge flag are provided. The block is the general-purpose replacement for single-channel, single-cycle rising-edge pulse logic, and sits between raw control/status inputs and downstream event consumers (counters, interrupt logic).

## Interface
- N_CH, 4: number of independent channels (1..32).
- CNT_W, 8: width of pulse-length field; maximum pulse length 2^CNT_W - 1 cycles.
- SYNC_STAGES, 0: flops of input synchroniser per channel before edge detect (0, 2 or 3).

- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- trigger  input  N_CH  per-channel trigger level.
- edge_mode  input  2  shared: 00 rising, 01 falling, 10 both, 11 disabled.
- pulse_len  input  CNT_W  shared pulse length in cycles; 0 treated as 1.
- retrig  input  1  1: an edge during an active pulse restarts the length count; 0: the edge is ignored.
- clr_missed  input  1  synchronous clear of all missed flags.
- pulse_out  output  N_CH  registered per-channel pulse.
- missed  output  N_CH  sticky: an edge arrived while pulse active and retrig=0.

## Operation
- Per channel: optional synchroniser (SYNC_STAGES flops) gives trg_s; one history flop trg_d holds the previous trg_s.
- Edge qualifies when trg_s != trg_d and the direction matches edge_mode (11 never qualifies).
- Per-channel FSM, IDLE / ACTIVE, with down-counter cnt[CNT_W-1:0]:
  - IDLE, qualifying edge: pulse_out<=1, cnt<=max(pulse_len,1)-1, go to ACTIVE if the loaded cnt != 0. Otherwise stay in IDLE; the pulse lasts exactly one cycle, because pulse_out clears next cycle unless another qualifying edge occurs.
  - ACTIVE, no edge: if cnt==0, then pulse_out<=0 and go to IDLE; else cnt<=cnt-1.
  - ACTIVE, qualifying edge, retrig=1: cnt<=max(pulse_len,1)-1; pulse_out stays 1. The pulse ends pulse_len cycles after this edge.
  - ACTIVE, qualifying edge, retrig=0: counting continues unchanged; missed[ch]<=1.
- The last cycle of a pulse (cnt==0) counts as active: an edge there is a retrigger or a missed edge, not a new pulse.
- pulse_len is sampled only on load/reload. Changing it mid-pulse does not affect the current count.
- edge_mode and retrig apply from the cycle they are presented.
- missed: set has priority over clr_missed in the same cycle.
- Channels are fully independent; the shared controls apply to all channels.
- Reset values: pulse_out=0, missed=0, trg_d=0, synchroniser flops=0, cnt=0, FSM=IDLE.
- Because trg_d resets to 0, a trigger held high through reset release yields a rising edge (mode 00 or 10) on the first sampled cycle.
- Reset asserted mid-pulse clears pulse_out immediately (asynchronously).

## Timing
- Latency, SYNC_STAGES=0: trigger sampled high at edge k (trg_d=0) gives pulse_out high after edge k. With a single-cycle pulse it is low again after edge k+1.
- Latency adds SYNC_STAGES cycles per synchroniser setting.
- Pulse width is exactly max(pulse_len,1) cycles for an isolated edge.
- Input toggling every cycle in mode 10 with retrig=1 keeps pulse_out continuously high.
- No combinational path from input to output.

## Test plan
- Reset with trigger=0, release, N_CH=4, edge_mode=00, pulse_len=1, ch0 rises at edge 3 -> pulse_out[0]=1 for exactly cycle 3→4, other channels 0, missed=0.
- edge_mode=01, pulse_len=5, ch1 falls -> pulse_out[1] high for exactly 5 cycles; its rising edge produces nothing. edge_mode=11: no pulse on any edge.
- pulse_len=4, retrig=0, second ch2 edge 2 cycles after the first (edge_mode=10) -> pulse width 4, missed[2]=1 and held. clr_missed -> 0. Set+clear in the same cycle -> stays 1.
- Same stimulus with retrig=1 -> pulse width 2+4=6 cycles, missed stays 0. Change pulse_len to 9 mid-pulse -> width unchanged until the next reload.
- pulse_len=0 -> 1-cycle pulse. pulse_len=255 (CNT_W=8) -> 255-cycle pulse, cnt wraps to IDLE with no extra cycle.
- SYNC_STAGES=2: latency = 3 edges from input change. Assert rst_n low mid-pulse -> pulse_out drops without waiting for clk. trigger held high across reset release in mode 00 -> one pulse.
